// File: rtl/nrisc_prog_loader_pkg.sv
// Shared state encoding and frame constants for the NRISC I-Data program loader.
package nrisc_prog_loader_pkg;

  localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;
  localparam int         LDR_MAX_WORDS = 1024;

  typedef enum logic [3:0] {
    LDR_IDLE   = 4'd0,
    LDR_SYNC   = 4'd1,
    LDR_CNT_H  = 4'd2,
    LDR_CNT_L  = 4'd3,
    LDR_ADR_H  = 4'd4,
    LDR_ADR_L  = 4'd5,
    LDR_DATA_H = 4'd6,
    LDR_DATA_L = 4'd7,
    LDR_WRITE  = 4'd8,
    LDR_CSUM   = 4'd9,
    LDR_DONE   = 4'd10,
    LDR_ERR    = 4'd11
  } ldr_state_e;

  // States that present ready=1 to the byte source.
  function automatic logic ldr_takes_byte(input ldr_state_e s);
    return s inside {LDR_SYNC, LDR_CNT_H, LDR_CNT_L, LDR_ADR_H, LDR_ADR_L,
                     LDR_DATA_H, LDR_DATA_L, LDR_CSUM};
  endfunction

  function automatic logic ldr_in_frame(input ldr_state_e s);
    return !(s inside {LDR_IDLE, LDR_DONE, LDR_ERR});
  endfunction

endpackage

// File: rtl/nrisc_prog_loader_csum.sv
// Modulo-256 frame checksum accumulator; zero reports whether the sum including
// the byte currently presented on add_byte would be zero.
module nrisc_loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] add_byte,
  output logic       zero
);

  logic [7:0] sum_q;
  logic [7:0] sum_nx;

  assign sum_nx = sum_q + add_byte;
  assign zero   = (sum_nx == 8'h00);

  always_ff @(posedge clk) begin
    if (rst || clr)  sum_q <= 8'h00;
    else if (add_en) sum_q <= sum_nx;
  end

endmodule

// File: rtl/nrisc_prog_loader.sv
// Boot-time program loader: parses A5-framed byte stream, writes 16-bit words to
// I-Data, verifies the frame checksum and holds the core in reset until a clean load.
import nrisc_prog_loader_pkg::*;

module nrisc_prog_loader #(
  parameter int         PROG_ADDR_W = 10,
  parameter int         PROG_DATA_W = 16,
  parameter int         MAX_WORDS   = LDR_MAX_WORDS,
  parameter logic [7:0] SYNC_BYTE   = LDR_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   LOADER_start,
  input  logic [7:0]             LOADER_byte_in,
  input  logic                   LOADER_byte_valid,
  output logic                   LOADER_byte_ready,
  output logic [PROG_DATA_W-1:0] IDATA_PROG_data,
  output logic [PROG_ADDR_W-1:0] IDATA_PROG_addr,
  output logic                   IDATA_PROG_write,
  output logic                   CORE_rst,
  output logic                   LOADER_busy,
  output logic                   LOADER_done,
  output logic                   LOADER_error
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);

  ldr_state_e             state_q, state_d;
  logic [7:0]             cnt_h_q;
  logic [7:0]             adr_h_q;
  logic [WC_W-1:0]        word_cnt_q;
  logic [PROG_ADDR_W-1:0] addr_q;
  logic [PROG_DATA_W-1:0] data_q;
  logic                   accept;
  logic                   csum_zero;
  logic [15:0]            cnt_in;
  logic [15:0]            adr_in;

  assign accept = LOADER_byte_valid & LOADER_byte_ready;
  assign cnt_in = {cnt_h_q, LOADER_byte_in};
  assign adr_in = {adr_h_q, LOADER_byte_in};

  nrisc_loader_csum u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == LDR_SYNC),
    .add_en   (accept && (state_q != LDR_SYNC)),
    .add_byte (LOADER_byte_in),
    .zero     (csum_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_IDLE:   if (LOADER_start) state_d = LDR_SYNC;
      LDR_SYNC:   if (accept && LOADER_byte_in == SYNC_BYTE) state_d = LDR_CNT_H;
      LDR_CNT_H:  if (accept) state_d = LDR_CNT_L;
      LDR_CNT_L:
        if (accept) begin
          if (cnt_in == 16'h0000 || int'(cnt_in) > MAX_WORDS) state_d = LDR_ERR;
          else                                                 state_d = LDR_ADR_H;
        end
      LDR_ADR_H:  if (accept) state_d = LDR_ADR_L;
      LDR_ADR_L:  if (accept) state_d = LDR_DATA_H;
      LDR_DATA_H: if (accept) state_d = LDR_DATA_L;
      LDR_DATA_L: if (accept) state_d = LDR_WRITE;
      LDR_WRITE:  state_d = (word_cnt_q == WC_W'(1)) ? LDR_CSUM : LDR_DATA_H;
      LDR_CSUM:   if (accept) state_d = csum_zero ? LDR_DONE : LDR_ERR;
      LDR_DONE:   if (LOADER_start) state_d = LDR_SYNC;
      LDR_ERR:    if (LOADER_start) state_d = LDR_SYNC;
      default:    state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LDR_IDLE;
      cnt_h_q    <= 8'h00;
      adr_h_q    <= 8'h00;
      word_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LDR_CNT_H:  if (accept) cnt_h_q <= LOADER_byte_in;
        LDR_CNT_L:  if (accept) word_cnt_q <= cnt_in[WC_W-1:0];
        LDR_ADR_H:  if (accept) adr_h_q <= LOADER_byte_in;
        LDR_ADR_L:  if (accept) addr_q <= adr_in[PROG_ADDR_W-1:0];
        LDR_DATA_H: if (accept) data_q[15:8] <= LOADER_byte_in;
        LDR_DATA_L: if (accept) data_q[7:0] <= LOADER_byte_in;
        // Address wraps silently at 2^PROG_ADDR_W.
        LDR_WRITE: begin
          addr_q     <= addr_q + 1'b1;
          word_cnt_q <= word_cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign LOADER_byte_ready = ldr_takes_byte(state_q);
  assign IDATA_PROG_write  = (state_q == LDR_WRITE);
  assign IDATA_PROG_data   = data_q;
  assign IDATA_PROG_addr   = addr_q;
  assign LOADER_busy       = ldr_in_frame(state_q);
  assign LOADER_done       = (state_q == LDR_DONE);
  assign LOADER_error      = (state_q == LDR_ERR);
  assign CORE_rst          = (state_q != LDR_DONE);

endmodule
